// File: rtl/quad_velocity.sv
// quad_velocity: velocity feedback derived from a free-running quadrature count.
//
// The 24-bit position count is sampled once per WINDOW_TICKS clocks. The
// wrap-safe signed delta between successive samples is averaged over the
// last 2^AVG_LOG2 windows. An encoder is flagged as stalled after
// STALL_WINDOWS consecutive windows with zero movement.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   count[23:0]    decoder position count (free-running, wraps)
//   clear          synchronous clear of history; re-baselines on the next sample
//   window_tick    one-cycle pulse in the cycle after each sample cycle
//   raw_delta      signed delta of the most recent window
//   velocity       signed moving average of the delta per window
//   velocity_valid one-cycle pulse when raw_delta/velocity/stalled update
//   stalled        high while the encoder has been idle for STALL_WINDOWS windows
module quad_velocity #(
    parameter int CLK_FREQ_HZ   = 32_000_000,
    parameter int WINDOW_US     = 1000,
    parameter int AVG_LOG2      = 2,
    parameter int STALL_WINDOWS = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] count,
    input  logic        clear,
    output logic        window_tick,
    output logic [23:0] raw_delta,
    output logic [23:0] velocity,
    output logic        velocity_valid,
    output logic        stalled
);
    localparam int WINDOW_TICKS = CLK_FREQ_HZ / 1_000_000 * WINDOW_US;
    localparam int WC_W         = $clog2(WINDOW_TICKS);
    localparam int DEPTH        = 1 << AVG_LOG2;
    localparam int PTR_W        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W        = 24 + AVG_LOG2;
    localparam int SC_W         = $clog2(STALL_WINDOWS + 1);

    typedef enum logic [1:0] {ST_BASELINE, ST_RUN, ST_UPDATE, ST_OUTPUT} state_t;

    state_t                   state_q, state_d;
    logic [WC_W-1:0]          wcnt_q, wcnt_d;
    logic                     tick_q, tick_d;
    logic [23:0]              count_prev_q, count_prev_d;
    logic [23:0]              delta_q, delta_d;
    logic [23:0]              raw_q, raw_d;
    logic [23:0]              vel_q, vel_d;
    logic                     valid_q, valid_d;
    logic                     stalled_q, stalled_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [23:0]              hist_q [DEPTH];
    logic [23:0]              hist_d [DEPTH];
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [SC_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic                     sample;

    always_comb begin
        sample       = (wcnt_q == WC_W'(WINDOW_TICKS - 1));
        wcnt_d       = sample ? '0 : wcnt_q + 1'b1;
        tick_d       = sample;
        state_d      = state_q;
        count_prev_d = count_prev_q;
        delta_d      = delta_q;
        raw_d        = raw_q;
        vel_d        = vel_q;
        valid_d      = 1'b0;
        stalled_d    = stalled_q;
        sum_d        = sum_q;
        hist_d       = hist_q;
        ptr_d        = ptr_q;
        stall_cnt_d  = stall_cnt_q;

        case (state_q)
            ST_BASELINE: begin
                if (sample) begin
                    count_prev_d = count;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sample) begin
                    // Modular subtraction makes the delta wrap-safe across 2^24.
                    delta_d      = count - count_prev_q;
                    count_prev_d = count;
                    state_d      = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // All result registers load at the end of UPDATE so the new
                // values and the valid pulse are visible together in OUTPUT (S+2).
                raw_d         = delta_q;
                sum_d         = sum_q + SUM_W'($signed(delta_q))
                                      - SUM_W'($signed(hist_q[ptr_q]));
                hist_d[ptr_q] = delta_q;
                ptr_d         = (AVG_LOG2 == 0) ? '0 : ptr_q + 1'b1;
                vel_d         = 24'(sum_d >>> AVG_LOG2);
                if (delta_q == 24'd0)
                    stall_cnt_d = (stall_cnt_q == SC_W'(STALL_WINDOWS)) ?
                                  stall_cnt_q : stall_cnt_q + 1'b1;
                else
                    stall_cnt_d = '0;
                stalled_d     = (stall_cnt_d == SC_W'(STALL_WINDOWS));
                valid_d       = 1'b1;
                state_d       = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_BASELINE;
        endcase

        // Clear overrides everything except the window counter/tick, so a
        // clear on the sample cycle leaves that sample unconsumed.
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
            sum_d       = '0;
            ptr_d       = '0;
            stall_cnt_d = '0;
            vel_d       = '0;
            raw_d       = '0;
            stalled_d   = 1'b0;
            valid_d     = 1'b0;
            state_d     = ST_BASELINE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_BASELINE;
            wcnt_q       <= '0;
            tick_q       <= 1'b0;
            count_prev_q <= '0;
            delta_q      <= '0;
            raw_q        <= '0;
            vel_q        <= '0;
            valid_q      <= 1'b0;
            stalled_q    <= 1'b0;
            sum_q        <= '0;
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            ptr_q        <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            tick_q       <= tick_d;
            count_prev_q <= count_prev_d;
            delta_q      <= delta_d;
            raw_q        <= raw_d;
            vel_q        <= vel_d;
            valid_q      <= valid_d;
            stalled_q    <= stalled_d;
            sum_q        <= sum_d;
            hist_q       <= hist_d;
            ptr_q        <= ptr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign window_tick    = tick_q;
    assign raw_delta      = raw_q;
    assign velocity       = vel_q;
    assign velocity_valid = valid_q;
    assign stalled        = stalled_q;
endmodule

// File: tb/tb_quad_velocity.sv
module tb_quad_velocity;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] count = 24'h000100;
    logic        window_tick, velocity_valid, stalled;
    logic [23:0] raw_delta, velocity;

    quad_velocity #(
        .CLK_FREQ_HZ(1_000_000), .WINDOW_US(10), .AVG_LOG2(2), .STALL_WINDOWS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .count(count), .clear(clear),
        .window_tick(window_tick), .raw_delta(raw_delta), .velocity(velocity),
        .velocity_valid(velocity_valid), .stalled(stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] raw;
        logic [23:0] vel;
        logic        st;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          last_vcyc = -1;
    logic        last_tick = 1'b0;

    // Reference model state
    int          mh[4];
    int          msum, mptr, mstall;
    logic        baseline;
    logic [23:0] mprev;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic int floor_div4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    task automatic model_reset();
        baseline = 1'b1;
        for (int i = 0; i < 4; i++) mh[i] = 0;
        msum = 0; mptr = 0; mstall = 0;
        sb.delete();
        last_vcyc = -1;
    endtask

    task automatic on_sample(input logic [23:0] c);
        logic [23:0] d;
        int          di;
        exp_t        e;
        if (baseline) begin
            mprev = c;
            baseline = 1'b0;
        end else begin
            d = c - mprev;
            di = int'($signed(d));
            mprev = c;
            msum = msum + di - mh[mptr];
            mh[mptr] = di;
            mptr = (mptr + 1) % 4;
            mstall = (di == 0) ? ((mstall < 3) ? mstall + 1 : 3) : 0;
            e.raw = d;
            e.vel = 24'(floor_div4(msum));
            e.st  = (mstall == 3);
            sb.push_back(e);
        end
    endtask

    // One clock: note what the DUT saw at this edge, drive the next inputs,
    // and feed the model if this edge was a sample edge.
    task automatic cyc(input logic [23:0] c, input logic clr, input logic rst);
        logic [23:0] ec;
        logic        eclr, erst;
        @(posedge clk);
        ec = count; eclr = clear; erst = reset_n;
        #1;
        count = c; clear = clr; reset_n = rst;
        cyc_n++;
        if (!erst || eclr) model_reset();
        @(negedge clk);
        last_tick = window_tick;
        if (window_tick && erst && !eclr) on_sample(ec);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(count, 1'b0, 1'b1);
    endtask

    // Advance until the cycle after a sample (window_tick high).
    task automatic sync();
        logic got = 1'b0;
        for (int i = 0; i < 15 && !got; i++) begin
            cyc(count, 1'b0, 1'b1);
            got = last_tick;
        end
        chk("sync_window_tick", {23'd0, got}, 24'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tick"},   {23'd0, window_tick},    24'd0);
        chk({tag, "_raw"},    raw_delta,               24'd0);
        chk({tag, "_vel"},    velocity,                24'd0);
        chk({tag, "_valid"},  {23'd0, velocity_valid}, 24'd0);
        chk({tag, "_stalled"},{23'd0, stalled},        24'd0);
    endtask

    always @(negedge clk) begin
        if (velocity_valid) begin
            exp_t e;
            chk("valid_expected", {23'd0, sb.size() != 0}, 24'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("raw_delta", raw_delta, e.raw);
                chk("velocity", velocity, e.vel);
                chk("stalled", {23'd0, stalled}, {23'd0, e.st});
            end
            if (last_vcyc >= 0) chk("valid_spacing", 24'(cyc_n - last_vcyc), 24'd10);
            last_vcyc = cyc_n;
        end
    end

    initial begin
        model_reset();
        // Reset with count parked at 0x000100
        cyc(24'h000100, 1'b0, 1'b0);
        cyc(24'h000100, 1'b0, 1'b1);
        chk_idle("reset");

        // 1: +1 every 2 cycles -> 5 per window, ramp 1,2,3,5,5
        for (int i = 0; i < 70; i++) cyc(count + 24'(i % 2), 1'b0, 1'b1);

        // 2: wrap forward (+5) and backward (-3)
        sync();
        cyc(24'hFFFFFE, 1'b0, 1'b1);
        sync();
        cyc(24'hFFFFFF, 1'b0, 1'b1);
        cyc(24'h000000, 1'b0, 1'b1);
        cyc(24'h000001, 1'b0, 1'b1);
        cyc(24'h000002, 1'b0, 1'b1);
        cyc(24'h000003, 1'b0, 1'b1);
        sync();
        cyc(24'h000002, 1'b0, 1'b1);
        sync();
        cyc(24'hFFFFFF, 1'b0, 1'b1);
        sync();
        hold(3);

        // 3: clear, then constant -7 per window from fresh history
        cyc(count, 1'b1, 1'b1);
        cyc(count, 1'b0, 1'b1);
        sync();
        sync();
        for (int w = 0; w < 6; w++) begin
            cyc(count - 24'd7, 1'b0, 1'b1);
            sync();
        end

        // 4: freeze -> stalled on third idle window; +1 clears it
        for (int w = 0; w < 4; w++) sync();
        cyc(count + 24'd1, 1'b0, 1'b1);
        sync();
        sync();
        hold(3);

        // 5: clear on a sample cycle; two windows without valid, then re-baselined delta
        sync();
        hold(8);
        cyc(count, 1'b1, 1'b1);
        cyc(count + 24'd3, 1'b0, 1'b1);
        sync();
        cyc(count + 24'd4, 1'b0, 1'b1);
        sync();
        hold(3);

        // 6: one-cycle reset at S+1 while an update is pending
        sync();
        for (int i = 0; i < 9; i++) cyc(count + 24'd1, 1'b0, 1'b1);
        cyc(count, 1'b0, 1'b0);
        cyc(count, 1'b0, 1'b1);
        chk_idle("midreset");
        sync();
        cyc(count + 24'd2, 1'b0, 1'b1);
        sync();
        cyc(count + 24'd6, 1'b0, 1'b1);
        sync();
        hold(12);

        chk("scoreboard_drained", 24'(sb.size()), 24'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
